// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions: format codes, base opcodes and the
// instruction-memory write payload. Used by the encoder and the decode-side
// controller.
package rv_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned OPC_W = 7;
   localparam int unsigned FMT_W = 3;

   // Format codes as presented on in_fmt; 6 and 7 are illegal
   typedef enum logic [FMT_W-1:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

   // Encoder run states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } enc_state_e;

   // One instruction-memory write: target byte address and word
   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } imem_wr_t;

   // True when the opcode belongs to the given format
   function automatic logic opcode_ok(input logic [FMT_W-1:0] fmt,
                                      input logic [OPC_W-1:0] op);
      logic ok;
      ok = 1'b0;
      case (fmt)
         FMT_R:   ok = (op == OPC_OP);
         FMT_I:   ok = (op == OPC_LOAD) || (op == OPC_OP_IMM) || (op == OPC_JALR);
         FMT_S:   ok = (op == OPC_STORE);
         FMT_B:   ok = (op == OPC_BRANCH);
         FMT_U:   ok = (op == OPC_LUI) || (op == OPC_AUIPC);
         FMT_J:   ok = (op == OPC_JAL);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/inst_imm_pack.sv
// Immediate packer: scatters the immediate into its RV32I bit positions for
// the given format and reports whether the value is representable.
//   i_fmt      format code
//   i_imm      signed byte offset / value
//   o_imm_bits immediate bits in place, all other bits zero
//   o_imm_ok   immediate in range (always true for R)
module inst_imm_pack
   import rv_pkg::*;
(
   input  logic [FMT_W-1:0] i_fmt,
   input  logic [XLEN-1:0]  i_imm,
   output logic [XLEN-1:0]  o_imm_bits,
   output logic             o_imm_ok
);

   logic w_fit12;
   logic w_fit13;
   logic w_fit21;

   // A value fits in N signed bits when bits [31:N-1] are all equal
   assign w_fit12 = (&i_imm[31:11]) || !(|i_imm[31:11]);
   assign w_fit13 = (&i_imm[31:12]) || !(|i_imm[31:12]);
   assign w_fit21 = (&i_imm[31:20]) || !(|i_imm[31:20]);

   always_comb begin
      o_imm_bits = '0;
      o_imm_ok   = 1'b0;
      case (i_fmt)
         FMT_R: begin
            o_imm_ok = 1'b1;
         end
         FMT_I: begin
            o_imm_bits = {i_imm[11:0], 20'd0};
            o_imm_ok   = w_fit12;
         end
         FMT_S: begin
            o_imm_bits = {i_imm[11:5], 13'd0, i_imm[4:0], 7'd0};
            o_imm_ok   = w_fit12;
         end
         FMT_B: begin
            o_imm_bits = {i_imm[12], i_imm[10:5], 13'd0, i_imm[4:1], i_imm[11], 7'd0};
            o_imm_ok   = w_fit13 && !i_imm[0];
         end
         FMT_U: begin
            o_imm_bits = {i_imm[31:12], 12'd0};
            o_imm_ok   = (i_imm[11:0] == 12'd0);
         end
         FMT_J: begin
            o_imm_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'd0};
            o_imm_ok   = w_fit21 && !i_imm[0];
         end
         default: begin
            o_imm_bits = '0;
            o_imm_ok   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: accepts field requests, encodes them into
// 32-bit words and writes them to consecutive instruction-memory addresses
// through a one-entry output stage.
//   clk, rst                 clock, async active-high reset
//   start, start_addr        begin a program at start_addr (IDLE only)
//   stop                     end of program: drain the stage, return to IDLE
//   in_valid/in_ready        field-request handshake
//   in_fmt .. in_imm         instruction fields
//   imem_we/ready/addr/wdata instruction-memory write port
//   busy, err, count         activity, sticky illegal-request flag, words written
module inst_encoder
   import rv_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [XLEN-1:0]  start_addr,
   input  logic             stop,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FMT_W-1:0] in_fmt,
   input  logic [OPC_W-1:0] in_opcode,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   output logic             imem_we,
   input  logic             imem_ready,
   output logic [XLEN-1:0]  imem_addr,
   output logic [XLEN-1:0]  imem_wdata,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] count
);

   enc_state_e       r_state;
   imem_wr_t         r_wr;
   logic             r_stage_valid;
   logic             r_err;
   logic [CNT_W-1:0] r_count;

   logic [XLEN-1:0]  w_imm_bits;
   logic             w_imm_ok;
   logic [XLEN-1:0]  w_fields;
   logic [XLEN-1:0]  w_word;
   logic             w_legal;
   logic             w_wr_done;
   logic             w_accept;

   inst_imm_pack u_imm_pack (
      .i_fmt      (in_fmt),
      .i_imm      (in_imm),
      .o_imm_bits (w_imm_bits),
      .o_imm_ok   (w_imm_ok)
   );

   // Register/opcode fields for each format; immediate bits are OR-ed in
   always_comb begin
      w_fields = '0;
      case (in_fmt)
         FMT_R:        w_fields = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I:        w_fields = {12'd0, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S, FMT_B: w_fields = {7'd0, in_rs2, in_rs1, in_funct3, 5'd0, in_opcode};
         FMT_U, FMT_J: w_fields = {20'd0, in_rd, in_opcode};
         default:      w_fields = '0;
      endcase
   end

   assign w_word    = w_fields | w_imm_bits;
   assign w_legal   = opcode_ok(in_fmt, in_opcode) && w_imm_ok;
   assign w_wr_done = r_stage_valid && imem_ready;
   assign in_ready  = (r_state == ST_RUN) && (!r_stage_valid || imem_ready);
   assign w_accept  = in_valid && in_ready;

   // Control FSM, output stage and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_wr          <= '0;
         r_stage_valid <= 1'b0;
         r_err         <= 1'b0;
         r_count       <= '0;
      end else begin
         // Address counter doubles as the stage's target address
         if (w_wr_done) begin
            r_wr.addr <= r_wr.addr + 32'd4;
            r_count   <= r_count + CNT_W'(1);
         end

         // A new word may enter in the same cycle the previous one retires
         if (w_accept && w_legal) begin
            r_stage_valid <= 1'b1;
            r_wr.data     <= w_word;
         end else if (w_wr_done) begin
            r_stage_valid <= 1'b0;
         end

         if (w_accept && !w_legal) begin
            r_err <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_RUN;
                  r_wr.addr <= start_addr;
                  r_count   <= '0;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!r_stage_valid || w_wr_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign imem_we    = r_stage_valid;
   assign imem_addr  = r_wr.addr;
   assign imem_wdata = r_wr.data;
   assign err        = r_err;
   assign count      = r_count;
   assign busy       = (r_state != ST_IDLE) || r_stage_valid;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed programs, a field-level
// encoding model and a write scoreboard checked on every completed write.
module tb_inst_encoder;

   localparam int unsigned CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [31:0]       start_addr;
   logic              stop;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [6:0]        in_opcode;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [31:0]       in_imm;
   logic              imem_we;
   logic              imem_ready;
   logic [31:0]       imem_addr;
   logic [31:0]       imem_wdata;
   logic              busy;
   logic              err;
   logic [CNT_W-1:0]  count;

   always #5 clk = ~clk;

   inst_encoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .stop       (stop),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_fmt     (in_fmt),
      .in_opcode  (in_opcode),
      .in_funct3  (in_funct3),
      .in_funct7  (in_funct7),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .imem_we    (imem_we),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .err        (err),
      .count      (count)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] m_addr;
   int          cyc = 0;
   int          wr_cycles[$];
   int          stall_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Encoding model: {legal, word} from the field rules
   function automatic logic [32:0] model_enc(input int fmt, input logic [6:0] op,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [31:0] imm);
      bit          opok;
      bit          immok;
      longint      s;
      logic [31:0] w;
      s = longint'($signed(imm));
      opok = 0;
      immok = 0;
      w = 32'(op);
      case (fmt)
         0: begin
            opok = (op == 7'h33);
            immok = 1;
            w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                  | (32'(rs2) << 20) | (32'(f7) << 25);
         end
         1: begin
            opok = (op == 7'h03) || (op == 7'h13) || (op == 7'h67);
            immok = (s >= -2048) && (s <= 2047);
            w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
         end
         2: begin
            opok = (op == 7'h23);
            immok = (s >= -2048) && (s <= 2047);
            w = w | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                  | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
         end
         3: begin
            opok = (op == 7'h63);
            immok = (s >= -4096) && (s <= 4095) && ((imm & 32'h1) == 0);
            w = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                  | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                  | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
         end
         4: begin
            opok = (op == 7'h37) || (op == 7'h17);
            immok = ((imm & 32'hFFF) == 0);
            w = w | (32'(rd) << 7) | (imm & 32'hFFFFF000);
         end
         5: begin
            opok = (op == 7'h6F);
            immok = (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && ((imm & 32'h1) == 0);
            w = w | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                  | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
         end
         default: begin
            opok = 0;
         end
      endcase
      return {opok && immok, w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request; pin the model against the hand value; log expectation on transfer
   task automatic send(input int fmt, input int op, input int f3, input int f7,
                       input int rd, input int rs1, input int rs2, input logic [31:0] imm,
                       input logic exp_legal, input logic [31:0] exp_word);
      logic [32:0] r;
      bit          got;
      r = model_enc(fmt, 7'(op), 3'(f3), 7'(f7), 5'(rd), 5'(rs1), 5'(rs2), imm);
      chk("model_legal", 32'(r[32]), 32'(exp_legal));
      if (exp_legal) chk("model_word", r[31:0], exp_word);
      in_fmt    = 3'(fmt);
      in_opcode = 7'(op);
      in_funct3 = 3'(f3);
      in_funct7 = 7'(f7);
      in_rd     = 5'(rd);
      in_rs1    = 5'(rs1);
      in_rs2    = 5'(rs2);
      in_imm    = imm;
      in_valid  = 1'b1;
      got = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_transfer required=transfer");
      end else if (r[32]) begin
         exp_q.push_back('{addr: m_addr, word: r[31:0]});
         m_addr = m_addr + 32'd4;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] a);
      start = 1'b1;
      start_addr = a;
      tick();
      start = 1'b0;
      m_addr = a;
      chk("start_addr", imem_addr, a);
      chk("start_count", 32'(count), 32'd0);
      chk("start_busy", 32'(busy), 32'd1);
   endtask

   task automatic do_stop_wait();
      bit idle;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      idle = 0;
      for (int k = 0; k < 40; k++) begin
         if (!busy) begin
            idle = 1;
            break;
         end
         tick();
      end
      chk("drain_idle", 32'(idle), 32'd1);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: every completed write must match the next expected word; stalls must hold
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_we", 32'(imem_we), 32'd1);
            chk("hold_addr", imem_addr, prev_addr);
            chk("hold_data", imem_wdata, prev_data);
         end
         if (imem_we && imem_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual=%h@%h required=none", imem_wdata, imem_addr);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", imem_addr, e.addr);
               chk("wr_data", imem_wdata, e.word);
            end
            wr_cycles.push_back(cyc);
         end
         prev_stall = imem_we && !imem_ready;
         if (prev_stall) stall_cycles++;
         prev_addr = imem_addr;
         prev_data = imem_wdata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int s0;
      rst = 1'b1;
      start = 1'b0;
      start_addr = '0;
      stop = 1'b0;
      in_valid = 1'b0;
      in_fmt = '0;
      in_opcode = '0;
      in_funct3 = '0;
      in_funct7 = '0;
      in_rd = '0;
      in_rs1 = '0;
      in_rs2 = '0;
      in_imm = '0;
      imem_ready = 1'b1;
      m_addr = '0;
      #12;
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // addi x1,x0,5 at 0x100
      do_start(32'h100);
      send(1, 'h13, 0, 0, 1, 0, 0, 32'd5, 1'b1, 32'h00500093);
      chk("lat1_we", 32'(imem_we), 32'd1);
      chk("lat1_addr", imem_addr, 32'h100);
      chk("lat1_data", imem_wdata, 32'h00500093);
      tick();
      chk("addi_count", 32'(count), 32'd1);
      chk("addi_next_addr", imem_addr, 32'h104);

      // add / sw / beq back to back
      n0 = wr_cycles.size();
      send(0, 'h33, 0, 0, 3, 1, 2, 32'd0, 1'b1, 32'h002081B3);
      send(2, 'h23, 2, 0, 0, 1, 2, 32'd8, 1'b1, 32'h0020A423);
      send(3, 'h63, 0, 0, 0, 1, 2, 32'd8, 1'b1, 32'h00208463);
      tick();
      tick();
      chk("b2b_writes", 32'(wr_cycles.size() - n0), 32'd3);
      if (wr_cycles.size() - n0 == 3) begin
         chk("b2b_gap1", 32'(wr_cycles[n0+1] - wr_cycles[n0]), 32'd1);
         chk("b2b_gap2", 32'(wr_cycles[n0+2] - wr_cycles[n0+1]), 32'd1);
      end
      chk("b2b_count", 32'(count), 32'd4);
      do_stop_wait();

      // jal with a 3-cycle memory stall, then lui
      do_start(32'h200);
      imem_ready = 1'b0;
      s0 = stall_cycles;
      fork
         begin
            repeat (4) tick();
            imem_ready = 1'b1;
         end
         begin
            send(5, 'h6F, 0, 0, 1, 0, 0, 32'd16, 1'b1, 32'h010000EF);
            send(4, 'h37, 0, 0, 5, 0, 0, 32'h12345000, 1'b1, 32'h123452B7);
         end
      join
      tick();
      tick();
      chk("stall_cycles", 32'(stall_cycles - s0), 32'd3);
      chk("stall_count", 32'(count), 32'd2);
      do_stop_wait();

      // address wrap
      do_start(32'hFFFFFFFC);
      send(1, 'h13, 0, 0, 2, 0, 0, 32'd1, 1'b1, 32'h00100113);
      send(1, 'h13, 0, 0, 3, 0, 0, 32'hFFFFFFFF, 1'b1, 32'hFFF00193);
      tick();
      tick();
      chk("wrap_addr", imem_addr, 32'h4);
      chk("wrap_count", 32'(count), 32'd2);
      do_stop_wait();

      // illegal requests: no writes, sticky err, address unchanged
      do_start(32'h300);
      chk("err_before", 32'(err), 32'd0);
      send(3, 'h63, 0, 0, 0, 1, 2, 32'd3, 1'b0, 32'h0);
      send(0, 'h13, 0, 0, 3, 1, 2, 32'd0, 1'b0, 32'h0);
      send(6, 'h13, 0, 0, 1, 0, 0, 32'd0, 1'b0, 32'h0);
      send(1, 'h13, 0, 0, 1, 0, 0, 32'd2048, 1'b0, 32'h0);
      send(4, 'h37, 0, 0, 5, 0, 0, 32'h12345001, 1'b0, 32'h0);
      tick();
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_we", 32'(imem_we), 32'd0);
      chk("ill_addr", imem_addr, 32'h300);
      chk("ill_count", 32'(count), 32'd0);
      send(1, 'h13, 0, 0, 1, 1, 0, 32'hFFFFF800, 1'b1, 32'h80008093);
      // start while running is ignored
      start = 1'b1;
      start_addr = 32'h500;
      tick();
      start = 1'b0;
      send(1, 'h13, 0, 0, 1, 0, 0, 32'd5, 1'b1, 32'h00500093);
      tick();
      tick();
      chk("ign_start_addr", imem_addr, 32'h308);
      chk("ill_err_sticky", 32'(err), 32'd1);
      chk("legal_after_ill_count", 32'(count), 32'd2);
      do_stop_wait();

      // stop with the stage full: word still written
      do_start(32'h400);
      chk("err_kept_on_start", 32'(err), 32'd1);
      send(1, 'h13, 0, 0, 1, 0, 0, 32'd5, 1'b1, 32'h00500093);
      imem_ready = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      imem_ready = 1'b1;
      for (int k = 0; k < 20 && busy; k++) tick();
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_count", 32'(count), 32'd1);
      chk("stop_addr", imem_addr, 32'h404);
      chk("stop_q_empty", 32'(exp_q.size()), 32'd0);

      // reset mid-stall: word discarded, outputs zero at once
      do_start(32'h600);
      imem_ready = 1'b0;
      send(1, 'h13, 0, 0, 1, 0, 0, 32'd5, 1'b1, 32'h00500093);
      tick();
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("mid_rst_we", 32'(imem_we), 32'd0);
      chk("mid_rst_addr", imem_addr, 32'd0);
      chk("mid_rst_wdata", imem_wdata, 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      imem_ready = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("post_rst_we", 32'(imem_we), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the written-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports start input 1 (begin program at start_addr) and start_addr input 32 (byte address of first word).
REQ-005 SHALL have port stop input 1, meaning end of program: drain and return to idle.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the field-request handshake.
REQ-007 SHALL have port in_fmt input 3, the format code: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 illegal.
REQ-008 SHALL have ports in_opcode input 7, in_funct3 input 3, in_funct7 input 7, in_rd/in_rs1/in_rs2 input 5 each, and in_imm input 32 (signed byte offset or value).
REQ-009 SHALL have ports imem_we output 1, imem_ready input 1, imem_addr output 32 and imem_wdata output 32, the instruction-memory write port.
REQ-010 SHALL have ports busy output 1, err output 1 (sticky) and count output CNT_W (words written).

Function
REQ-011 SHALL implement states IDLE, RUN and DRAIN; IDLE->RUN on start, RUN->DRAIN on stop, DRAIN->IDLE when the stage is empty; start outside IDLE is ignored.
REQ-012 SHALL load the address counter from start_addr and clear count on IDLE->RUN; err is not cleared.
REQ-013 SHALL assert in_ready = (state==RUN) && (!stage_valid || imem_ready); a transfer occurs when in_valid && in_ready.
REQ-014 SHALL register each accepted legal request into a one-entry output stage, so imem_we rises the cycle after acceptance (latency 1).
REQ-015 SHALL hold imem_we/addr/wdata stable while imem_we && !imem_ready; a write completes on imem_we && imem_ready.
REQ-016 SHALL increment the address by 4 (wrapping modulo 2^32) and count by 1 (wrapping modulo 2^CNT_W) on each completed write.
REQ-017 SHALL accept a new request in the same cycle the stage completes its write (full throughput, one word per cycle).
REQ-018 SHALL encode RV32I fields exactly: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-019 SHALL flag the opcode as illegal unless it matches the format: R 0110011; I 0000011, 0010011 or 1100111; S 0100011; B 1100011; U 0110111 or 0010111; J 1101111.
REQ-020 SHALL flag the immediate as illegal when it is out of range: I/S outside signed 12-bit; B outside signed 13-bit or bit0 set; J outside signed 21-bit or bit0 set; U with imm[11:0] nonzero.
REQ-021 SHALL, on an illegal request (format, opcode or immediate), complete the handshake, set err, and write nothing; the address is unchanged.
REQ-022 SHALL still write an in-flight stage word when stop is asserted in the same cycle, and accept no new request after stop.
REQ-023 SHALL drive busy high when state is not IDLE or the stage is valid.

Reset
REQ-024 SHALL on rst, immediately and asynchronously, enter IDLE and set imem_we=0, imem_addr=0, imem_wdata=0, count=0, err=0, busy=0 and in_ready=0.
REQ-025 SHALL discard a pending stage word on reset asserted mid-write, with no partial write.

Structure
REQ-026 SHALL take opcode constants and the format-code enum from shared package rv_pkg, which the decode-side controller also uses.
REQ-027 SHALL place immediate packing and range checking in a combinational sub-module inst_imm_pack.

Verification
REQ-028 SHALL verify start with start_addr=0x100, then addi x1,x0,5 -> write 0x00500093 at 0x100, count=1.
REQ-029 SHALL verify back-to-back add x3,x1,x2; sw x2,8(x1); beq x1,x2,+8 -> 0x002081B3, 0x0020A423 and 0x00208463 at consecutive addresses, one per cycle.
REQ-030 SHALL verify jal x1,+16 then lui x5,0x12345000, with imem_ready low for 3 cycles -> 0x010000EF held stable, then 0x123452B7 written.
REQ-031 SHALL verify a B request with imm=3 and an R request with opcode 0010011 -> err=1, no writes, address unchanged.
REQ-032 SHALL verify start_addr=0xFFFFFFFC with two legal words -> writes at 0xFFFFFFFC then 0x00000000.
REQ-033 SHALL verify stop asserted with the stage full and rst asserted mid-stall -> the word is written, then IDLE; on reset all outputs are zero.
